// File: rtl/dmem_pkg.sv
// Purpose: shared types and helpers for the data-memory responder.
// Latency: n/a (types, constants and a combinational lane-merge helper).
// Backpressure: n/a.
package dmem_pkg;

  // Status FSM encoding.
  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // Read data returned for addresses beyond the array.
  localparam logic [31:0] OOB_RDATA = 32'hDEADBEEF;

  // Replace the byte lanes selected by wen with the matching lanes of wdata.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (wen[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Purpose: CPU data-memory bus (address, write data, lane enables, read data).
// Latency: read data is combinational from the address; writes land on the next edge.
// Backpressure: none; the memory side accepts every cycle.
// Ports: master = CPU side (drives addr/wdata/wen), slave = memory side (drives rdata).
interface dmem_responder_if;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_wen;
  logic [31:0] d_mem_rdata;

  modport master (
    output d_mem_addr,
    output d_mem_wdata,
    output d_mem_wen,
    input  d_mem_rdata
  );

  modport slave (
    input  d_mem_addr,
    input  d_mem_wdata,
    input  d_mem_wen,
    output d_mem_rdata
  );
endinterface

// File: rtl/dmem_bytelane_ram.sv
// Purpose: WORDS x 32 RAM with per-byte-lane synchronous write and two async read ports.
// Latency: reads combinational; writes visible after the next rising edge.
// Backpressure: none.
// Ports: clk; we/waddr/wdata write port; raddr_a/rdata_a and raddr_b/rdata_b read ports.
module dmem_bytelane_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [31:0]   rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [31:0]   rdata_b
);

  logic [31:0] mem [WORDS];

  // Contents are deliberately not reset; the parent sweeps zeros in after reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dmem_responder.sv
// Purpose: data-memory end of the CPU bus: clear sweep, byte-lane RAM, run status (done/timeout/oob).
// Latency: zero-cycle reads, writes and status updates on the next rising edge.
// Backpressure: none; writes during the clear sweep are silently dropped.
// Ports: clk, rst (async active-high); bus (slave modport); ready/done/timeout/err_oob/oob_count/
//        cycle_count status; result_rd_idx/result_rd_data inspection window.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          MEM_WORDS      = 1024,
  parameter logic [31:0] RESULT_BASE    = 32'h200,
  parameter int          RESULT_WORDS   = 6,
  parameter logic [31:0] DONE_ADDR      = 32'h300,
  parameter int          TIMEOUT_CYCLES = 10000
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic              ready,
  output logic              done,
  output logic              timeout,
  output logic              err_oob,
  output logic [15:0]       oob_count,
  output logic [31:0]       cycle_count,
  input  logic [2:0]        result_rd_idx,
  output logic [31:0]       result_rd_data
);

  localparam int            AW        = $clog2(MEM_WORDS);
  localparam logic [31:0]   MEM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [AW-1:0] LAST_IDX  = AW'(MEM_WORDS - 1);
  localparam logic [AW-1:0] RES_WORD  = AW'(RESULT_BASE >> 2);
  localparam logic [29:0]   DONE_WORD = DONE_ADDR[31:2];
  localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] clear_idx_q, clear_idx_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          err_oob_q, err_oob_d;
  logic [15:0]   oob_count_q, oob_count_d;
  logic [31:0]   cycle_count_q, cycle_count_d;

  logic          clearing;
  logic          in_range;
  logic          wr_req;
  logic          done_wr;
  logic [AW-1:0] word_idx;
  logic [AW-1:0] res_idx;
  logic [31:0]   ram_rdata_a;
  logic [31:0]   ram_rdata_b;
  logic [31:0]   merged;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;

  assign clearing = (state_q == ST_CLEAR);
  assign in_range = (bus.d_mem_addr < MEM_BYTES);
  assign wr_req   = |bus.d_mem_wen;
  assign word_idx = bus.d_mem_addr[AW+1:2];
  assign res_idx  = RES_WORD + AW'(result_rd_idx);

  // Value the addressed word will hold after this cycle's write; drives mailbox decode.
  assign merged  = lane_merge(ram_rdata_a, bus.d_mem_wdata, bus.d_mem_wen);
  assign done_wr = (state_q == ST_RUN) && wr_req && in_range &&
                   (bus.d_mem_addr[31:2] == DONE_WORD) && (merged == 32'h1);

  // Single write port shared between the clear sweep and the CPU.
  always_comb begin
    ram_we    = 4'h0;
    ram_waddr = word_idx;
    ram_wdata = bus.d_mem_wdata;
    if (clearing) begin
      ram_we    = 4'hF;
      ram_waddr = clear_idx_q;
      ram_wdata = 32'h0;
    end else if (in_range) begin
      ram_we    = bus.d_mem_wen;
    end
  end

  dmem_bytelane_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (word_idx),
    .rdata_a (ram_rdata_a),
    .raddr_b (res_idx),
    .rdata_b (ram_rdata_b)
  );

  // Reads return zero until the sweep has finished so stale contents never leak out.
  always_comb begin
    bus.d_mem_rdata = 32'h0;
    if (!clearing) bus.d_mem_rdata = in_range ? ram_rdata_a : OOB_RDATA;
  end

  always_comb begin
    result_rd_data = 32'h0;
    if (!clearing && ({29'd0, result_rd_idx} < 32'(RESULT_WORDS))) result_rd_data = ram_rdata_b;
  end

  always_comb begin
    state_d       = state_q;
    clear_idx_d   = clear_idx_q;
    ready_d       = ready_q;
    done_d        = done_q;
    timeout_d     = timeout_q;
    err_oob_d     = err_oob_q;
    oob_count_d   = oob_count_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      ST_CLEAR: begin
        clear_idx_d = clear_idx_q + 1'b1;
        if (clear_idx_q == LAST_IDX) begin
          state_d       = ST_RUN;
          ready_d       = 1'b1;
          cycle_count_d = 32'h0;
        end
      end
      ST_RUN: begin
        // A mailbox hit on the timeout boundary cycle takes priority over the timeout.
        if (done_wr) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (cycle_count_q == TO_LAST) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end else begin
          cycle_count_d = cycle_count_q + 32'h1;
        end
      end
      default: ;
    endcase

    if (!clearing && wr_req && !in_range) begin
      err_oob_d = 1'b1;
      if (oob_count_q != 16'hFFFF) oob_count_d = oob_count_q + 16'h1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      clear_idx_q   <= '0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      err_oob_q     <= 1'b0;
      oob_count_q   <= 16'h0;
      cycle_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      clear_idx_q   <= clear_idx_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      err_oob_q     <= err_oob_d;
      oob_count_q   <= oob_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign err_oob     = err_oob_q;
  assign oob_count   = oob_count_q;
  assign cycle_count = cycle_count_q;

endmodule
